// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: mode constant sets, sync polarity codes
// and a helper that sizes counters for a given axis total.
package vga_timing_pkg;

    localparam logic SYNC_NEG = 1'b0;
    localparam logic SYNC_POS = 1'b1;

    // 640x480@60, 25.175 MHz nominal; run from clk25
    localparam int   VGA640_H_ACTIVE = 640;
    localparam int   VGA640_H_FP     = 16;
    localparam int   VGA640_H_SYNC   = 96;
    localparam int   VGA640_H_BP     = 48;
    localparam int   VGA640_V_ACTIVE = 480;
    localparam int   VGA640_V_FP     = 10;
    localparam int   VGA640_V_SYNC   = 2;
    localparam int   VGA640_V_BP     = 33;
    localparam logic VGA640_H_POL    = SYNC_NEG;
    localparam logic VGA640_V_POL    = SYNC_NEG;

    // 800x600@60, 40 MHz nominal; kept for a future faster pixel clock
    localparam int   SVGA800_H_ACTIVE = 800;
    localparam int   SVGA800_H_FP     = 40;
    localparam int   SVGA800_H_SYNC   = 128;
    localparam int   SVGA800_H_BP     = 88;
    localparam int   SVGA800_V_ACTIVE = 600;
    localparam int   SVGA800_V_FP     = 1;
    localparam int   SVGA800_V_SYNC   = 4;
    localparam int   SVGA800_V_BP     = 23;
    localparam logic SVGA800_H_POL    = SYNC_POS;
    localparam logic SVGA800_V_POL    = SYNC_POS;

    // Smallest width w with 2^w > total, so total itself is representable.
    function automatic int min_cw(input int total);
        int w;
        w = 1;
        while ((1 << w) <= total) w++;
        return w;
    endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// ce-gated shift register that re-times sync/enable bits to match the
// downstream pixel pipeline; DEPTH=0 collapses to a wire.
module sync_delay_line #(
    parameter int             DEPTH   = 2,
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk25,
    input  logic         rst,
    input  logic         ce,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_in;
            assign unused_in = ^{clk25, rst, ce};
            assign q = d;
        end else begin : g_pipe
            logic [W-1:0] stage [DEPTH];

            always_ff @(posedge clk25 or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
                end else if (ce) begin
                    stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing: free-running h/v counters, registered
// position/sync/enable outputs, line/frame/vblank strobes and a delayed copy.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = VGA640_H_ACTIVE,
    parameter int   H_FP     = VGA640_H_FP,
    parameter int   H_SYNC   = VGA640_H_SYNC,
    parameter int   H_BP     = VGA640_H_BP,
    parameter int   V_ACTIVE = VGA640_V_ACTIVE,
    parameter int   V_FP     = VGA640_V_FP,
    parameter int   V_SYNC   = VGA640_V_SYNC,
    parameter int   V_BP     = VGA640_V_BP,
    parameter logic H_POL    = VGA640_H_POL,
    parameter logic V_POL    = VGA640_V_POL,
    parameter int   CW       = 10,
    parameter int   PIPE_DLY = 2
) (
    input  logic          clk25,
    input  logic          rst,
    input  logic          ce,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          de,
    output logic          hsync,
    output logic          vsync,
    output logic          line_start,
    output logic          frame_start,
    output logic          vblank_start,
    output logic          de_d,
    output logic          hsync_d,
    output logic          vsync_d
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
            V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_len_chk
            $fatal(1, "vga_timing_gen: every timing length must be at least 1");
        end
        if (CW < min_cw(H_TOTAL) || CW < min_cw(V_TOTAL)) begin : g_cw_chk
            $fatal(1, "vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
        end
        if (PIPE_DLY < 0 || PIPE_DLY > 15) begin : g_dly_chk
            $fatal(1, "vga_timing_gen: PIPE_DLY must be 0..15");
        end
    endgenerate

    localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] H_HS_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] V_VS_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);

    logic [CW-1:0] hc;
    logic [CW-1:0] vc;
    logic          hs_on;
    logic          vs_on;

    assign hs_on = (hc >= H_HS_BEG) && (hc < H_HS_END);
    assign vs_on = (vc >= V_VS_BEG) && (vc < V_VS_END);

    // Outputs sample hc/vc on the same ce edge that advances them, so the
    // presented position always trails the counters by one ce-cycle.
    always_ff @(posedge clk25 or negedge rst) begin
        if (!rst) begin
            hc           <= '0;
            vc           <= '0;
            x            <= '0;
            y            <= '0;
            de           <= 1'b0;
            hsync        <= ~H_POL;
            vsync        <= ~V_POL;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
        end else begin
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
            if (ce) begin
                x            <= hc;
                y            <= vc;
                de           <= (hc < H_ACT_C) && (vc < V_ACT_C);
                hsync        <= hs_on ? H_POL : ~H_POL;
                vsync        <= vs_on ? V_POL : ~V_POL;
                line_start   <= (hc == '0);
                frame_start  <= (hc == '0) && (vc == '0);
                vblank_start <= (hc == '0) && (vc == V_ACT_C);
                if (hc == H_LAST) begin
                    hc <= '0;
                    vc <= (vc == V_LAST) ? '0 : vc + CW'(1);
                end else begin
                    hc <= hc + CW'(1);
                end
            end
        end
    end

    logic [2:0] dly_d;
    logic [2:0] dly_q;

    assign dly_d = {de, hsync, vsync};

    sync_delay_line #(
        .DEPTH   (PIPE_DLY),
        .W       (3),
        .RST_VAL ({1'b0, ~H_POL, ~V_POL})
    ) u_dly (
        .clk25 (clk25),
        .rst   (rst),
        .ce    (ce),
        .d     (dly_d),
        .q     (dly_q)
    );

    assign {de_d, hsync_d, vsync_d} = dly_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised successor to the existing VGA sync counter. It produces horizontal and vertical timing for any display mode. Each axis is described by active, front-porch, sync and back-porch lengths, and each sync has its own polarity. A pixel clock-enable lets lower pixel rates run from clk25. All outputs are registered and mutually aligned. Line, frame and vblank strobes are provided, plus a second copy of de/hsync/vsync delayed to match downstream pixel-pipeline latency. It sits between clk25 and the sprite/pixel generators and drives the DAC sync pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, hsync asserted level (0 = active-low)
V_POL, 0, vsync asserted level (0 = active-low)
CW, 10, counter/coordinate width
PIPE_DLY, 2, ce-cycles of delay on the *_d outputs (0..15)

Ports:
clk25  in  1  pixel-domain clock, 25 MHz
rst  in  1  reset, asynchronous, active-low
ce  in  1  pixel advance enable; tie high for full rate
x  out  CW  horizontal position; counts through blanking
y  out  CW  vertical position; counts through blanking
de  out  1  1 when (x,y) is inside the active area
hsync  out  1  horizontal sync at H_POL level
vsync  out  1  vertical sync at V_POL level
line_start  out  1  one-clk25 strobe when x==0
frame_start  out  1  one-clk25 strobe when x==0 and y==0
vblank_start  out  1  one-clk25 strobe when x==0 and y==V_ACTIVE
de_d  out  1  de delayed PIPE_DLY ce-cycles
hsync_d  out  1  hsync delayed PIPE_DLY ce-cycles
vsync_d  out  1  vsync delayed PIPE_DLY ce-cycles

Behaviour:
- Derived constants:
  - H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP (800 at defaults).
  - V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP (525 at defaults).
  - Axis ordering is active, front porch, sync, back porch.
- Elaboration check: 2^CW > H_TOTAL and 2^CW > V_TOTAL, and every length ≥ 1. A violation is a fatal elaboration error.
- Internal counters hc, vc; reset value 0.
  - On each clk25 with ce=1: hc increments; at H_TOTAL-1 it wraps to 0.
  - vc increments on each hc wrap; at V_TOTAL-1 it wraps to 0.
- Output registers load from hc/vc on each ce=1 cycle, so outputs trail the counters by exactly 1 ce-cycle and are all aligned with each other.
  - x = hc, y = vc.
  - de = (hc < H_ACTIVE) && (vc < V_ACTIVE).
  - hsync = H_POL while H_ACTIVE+H_FP ≤ hc < H_ACTIVE+H_FP+H_SYNC; otherwise ~H_POL.
  - vsync uses the V parameters and V_POL the same way.
- Strobes are registered together with x/y and are high for exactly one clk25 cycle, the cycle in which the matching position is first presented.
  - With ce=0 all strobes are 0, and x, y, de, hsync, vsync hold their values.
- Delay line: a PIPE_DLY-deep shift register that advances only on ce=1.
  - With PIPE_DLY=0, *_d equal the undelayed outputs combinationally.
  - Delay stages reset to de=0 and sync inactive.
- Reset values of every output: x=0, y=0, de=0, hsync=~H_POL, vsync=~V_POL, all strobes 0, de_d=0, hsync_d=~H_POL, vsync_d=~V_POL.
- First ce cycle after reset release presents (0,0), de=1, line_start=1, frame_start=1.
- Reset asserted mid-frame: every register returns to its reset value immediately (asynchronous). There is no partial-frame completion.
- Boundary conditions:
  - Simultaneous hc and vc wrap is a normal transition to (0,0).
  - ce toggling on every cycle halves the frame rate; no strobe is duplicated or lost.

Decomposition:
- Shared package vga_timing_pkg:
  - Mode constant sets: 640x480@60 (defaults), 800x600 timings for later use.
  - Polarity constants SYNC_NEG=0, SYNC_POS=1.
  - Function computing the minimum CW from a total.
- Sub-module sync_delay_line: parameters DEPTH, W; ports clk25, rst, ce, d, q; parametrised reset value. Instantiated once with W=3.

Test Plan:
- Defaults, ce=1, release reset: first x/y = (0,0) with de=1 and frame_start=1. hsync is low for exactly x=656..751 (96 cycles). de is low for x ≥ 640.
- Defaults, count clk25 cycles between frame_start pulses → 420000 exactly. vsync is low only during y=490..491 (1600 cycles). vblank_start fires once per frame, at y=480, x=0.
- ce high on alternate cycles → 840000 clk25 cycles per frame. Each strobe is exactly one clk25 wide and occurs exactly once per line/frame. x holds value during ce=0.
- PIPE_DLY=2 with ce=1 → de_d, hsync_d, vsync_d equal de, hsync, vsync shifted by 2 cycles. PIPE_DLY=0 → *_d identical to the undelayed outputs.
- H_POL=1, V_POL=1 → hsync high only for x=656..751. After reset, hsync=0 and hsync_d=0.
- Assert rst at x=300, y=200 → all outputs take their reset values within the same cycle. After release, the frame restarts at (0,0) with frame_start=1.
